// File: rtl/p1v_reset_ctl_if.sv
// Reset-controller signal bundle between board-level reset logic and the p1v core.
// The board side drives the reset requests; the controller drives the core reset and status.
interface p1v_reset_ctl_if;
  logic       btn_resn;
  logic       soft_req;
  logic       inp_resn;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output btn_resn,
    output soft_req,
    input  inp_resn,
    input  reset_cause,
    input  reset_count
  );

  modport slave (
    input  btn_resn,
    input  soft_req,
    output inp_resn,
    output reset_cause,
    output reset_count
  );
endinterface

// File: rtl/p1v_reset_ctl.sv
// Core reset controller for p1v: merges power-on, debounced button and software reboot
// into a stretched active-low reset, recording the last cause and a saturating reset count.
module p1v_reset_ctl #(
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter int STRETCH_CYCLES  = 160000,
  parameter int CNT_W           = 24
) (
  input  logic            clock_160,
  input  logic            res,
  p1v_reset_ctl_if.slave  rif
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RUN,
    ST_QUAL
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_POR  = 2'b01,
    CAUSE_BTN  = 2'b10,
    CAUSE_SW   = 2'b11
  } cause_t;

  localparam logic [CNT_W-1:0] STRETCH_LAST  = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta;
  logic             btn_s;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  cause_t           cause, cause_d;
  logic [7:0]       count, count_d;
  logic             bump;
  logic             inp_resn_q;

  // Both flops clear to 0 so reset cannot end until a released button has been seen.
  always_ff @(posedge clock_160) begin
    if (res) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= rif.btn_resn;
      btn_s    <= btn_meta;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_160) begin
    if (res) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      cause      <= CAUSE_POR;
      count      <= 8'd0;
      inp_resn_q <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cause      <= cause_d;
      count      <= count_d;
      inp_resn_q <= (state_d != ST_ASSERT);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state;
    cnt_d   = cnt;
    cause_d = cause;
    bump    = 1'b0;

    unique case (state)
      ST_ASSERT: begin
        if (cnt != STRETCH_LAST) begin
          cnt_d = cnt + 1'b1;
        end else if (btn_s && !rif.soft_req) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (rif.soft_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          cause_d = CAUSE_SW;
          bump    = 1'b1;
        end else if (!btn_s) begin
          state_d = ST_QUAL;
          cnt_d   = '0;
        end
      end

      ST_QUAL: begin
        // The core keeps running while the button is being qualified.
        if (rif.soft_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          cause_d = CAUSE_SW;
          bump    = 1'b1;
        end else if (btn_s) begin
          state_d = ST_RUN;
        end else if (cnt == DEBOUNCE_LAST) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          cause_d = CAUSE_BTN;
          bump    = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    count_d = (bump && count != 8'hFF) ? count + 8'd1 : count;
  end

  assign rif.inp_resn    = inp_resn_q;
  assign rif.reset_cause = cause;
  assign rif.reset_count = count;

endmodule

// File: tb/tb_p1v_reset_ctl.sv
// Directed bench for p1v_reset_ctl with DEBOUNCE_CYCLES=8 and STRETCH_CYCLES=4;
// inputs change and outputs are sampled 1 ns after each rising edge.
module tb_p1v_reset_ctl;
  localparam int DEB = 8;
  localparam int STR = 4;

  logic clock_160 = 1'b0;
  logic res;
  p1v_reset_ctl_if rif ();

  p1v_reset_ctl #(
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STR),
    .CNT_W          (24)
  ) dut (
    .clock_160(clock_160),
    .res      (res),
    .rif      (rif.slave)
  );

  always #5 clock_160 = ~clock_160;

  int passed = 0;
  int total  = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clock_160);
    #1;
  endtask

  task automatic wait_resn_high(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rif.inp_resn === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    res = 1'b1;
    rif.btn_resn = 1'b1;
    rif.soft_req = 1'b0;
    tick(3);
    res = 1'b0;
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL por_assert: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    total++; if (rif.reset_cause !== 2'b01) $display("FAIL por_cause: cause=%b expected 01", rif.reset_cause); else passed++;
    total++; if (rif.reset_count !== 8'd0) $display("FAIL por_count: count=%0d expected 0", rif.reset_count); else passed++;
    for (int i = 1; i < STR; i++) begin
      tick(1);
      total++; if (rif.inp_resn !== 1'b0) $display("FAIL por_low[%0d]: inp_resn=%b expected 0", i, rif.inp_resn); else passed++;
    end
    tick(1);
    total++; if (rif.inp_resn !== 1'b1) $display("FAIL por_release: inp_resn=%b expected 1", rif.inp_resn); else passed++;
  endtask

  task automatic test_glitch;
    rif.btn_resn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 4) rif.btn_resn = 1'b1;
      total++; if (rif.inp_resn !== 1'b1) $display("FAIL glitch_run[%0d]: inp_resn=%b expected 1", i, rif.inp_resn); else passed++;
    end
    total++; if (rif.reset_count !== 8'd0) $display("FAIL glitch_count: count=%0d expected 0", rif.reset_count); else passed++;
  endtask

  task automatic test_valid_press;
    rif.btn_resn = 1'b0;
    for (int i = 1; i <= 2 + 1 + DEB - 1; i++) begin
      tick(1);
      total++; if (rif.inp_resn !== 1'b1) $display("FAIL press_qual[%0d]: inp_resn=%b expected 1", i, rif.inp_resn); else passed++;
    end
    tick(1);
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL press_fall: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    total++; if (rif.reset_cause !== 2'b10) $display("FAIL press_cause: cause=%b expected 10", rif.reset_cause); else passed++;
    total++; if (rif.reset_count !== 8'd1) $display("FAIL press_count: count=%0d expected 1", rif.reset_count); else passed++;
    for (int i = 12; i <= 20; i++) begin
      tick(1);
      total++; if (rif.inp_resn !== 1'b0) $display("FAIL press_hold[%0d]: inp_resn=%b expected 0", i, rif.inp_resn); else passed++;
    end
    rif.btn_resn = 1'b1;
    tick(2);
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL press_sync_low: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    tick(1);
    total++; if (rif.inp_resn !== 1'b1) $display("FAIL press_release: inp_resn=%b expected 1", rif.inp_resn); else passed++;
    total++; if (rif.reset_count !== 8'd1) $display("FAIL press_count_hold: count=%0d expected 1", rif.reset_count); else passed++;
  endtask

  task automatic test_soft;
    rif.soft_req = 1'b1;
    tick(1);
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL soft_fall: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    total++; if (rif.reset_cause !== 2'b11) $display("FAIL soft_cause: cause=%b expected 11", rif.reset_cause); else passed++;
    total++; if (rif.reset_count !== 8'd2) $display("FAIL soft_count: count=%0d expected 2", rif.reset_count); else passed++;
    tick(1);
    rif.soft_req = 1'b0;
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL soft_low2: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    tick(2);
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL soft_low4: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    tick(1);
    total++; if (rif.inp_resn !== 1'b1) $display("FAIL soft_release: inp_resn=%b expected 1", rif.inp_resn); else passed++;

    rif.soft_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      total++; if (rif.inp_resn !== 1'b0) $display("FAIL soft_held[%0d]: inp_resn=%b expected 0", i, rif.inp_resn); else passed++;
    end
    rif.soft_req = 1'b0;
    total++; if (rif.reset_count !== 8'd3) $display("FAIL soft_held_count: count=%0d expected 3", rif.reset_count); else passed++;
    tick(1);
    total++; if (rif.inp_resn !== 1'b1) $display("FAIL soft_held_release: inp_resn=%b expected 1", rif.inp_resn); else passed++;
  endtask

  task automatic test_simultaneous;
    bit ok;
    rif.btn_resn = 1'b0;
    tick(2);
    rif.soft_req = 1'b1;
    tick(1);
    rif.soft_req = 1'b0;
    rif.btn_resn = 1'b1;
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL simul_fall: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    total++; if (rif.reset_cause !== 2'b11) $display("FAIL simul_cause: cause=%b expected 11", rif.reset_cause); else passed++;
    total++; if (rif.reset_count !== 8'd4) $display("FAIL simul_count: count=%0d expected 4", rif.reset_count); else passed++;
    wait_resn_high(20, ok);
    total++; if (!ok) $display("FAIL simul_timeout: inp_resn=%b expected 1 within 20 clocks", rif.inp_resn); else passed++;
    total++; if (rif.reset_count !== 8'd4) $display("FAIL simul_count_final: count=%0d expected 4", rif.reset_count); else passed++;
  endtask

  task automatic test_saturation;
    bit ok;
    bit all_ok = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      rif.soft_req = 1'b1;
      tick(1);
      rif.soft_req = 1'b0;
      wait_resn_high(20, ok);
      if (!ok) all_ok = 1'b0;
      if (n == 100) begin
        total++; if (rif.reset_count !== 8'd104) $display("FAIL sat_mid_count: count=%0d expected 104", rif.reset_count); else passed++;
      end
    end
    total++; if (!all_ok) $display("FAIL sat_timeout: some reboot did not release within 20 clocks, got %b expected 1", all_ok); else passed++;
    total++; if (rif.reset_count !== 8'd255) $display("FAIL sat_count: count=%0d expected 255", rif.reset_count); else passed++;

    rif.soft_req = 1'b1;
    tick(1);
    rif.soft_req = 1'b0;
    tick(1);
    res = 1'b1;
    tick(1);
    res = 1'b0;
    total++; if (rif.reset_count !== 8'd0) $display("FAIL ovr_count: count=%0d expected 0", rif.reset_count); else passed++;
    total++; if (rif.reset_cause !== 2'b01) $display("FAIL ovr_cause: cause=%b expected 01", rif.reset_cause); else passed++;
    total++; if (rif.inp_resn !== 1'b0) $display("FAIL ovr_assert: inp_resn=%b expected 0", rif.inp_resn); else passed++;
    for (int i = 1; i < STR; i++) begin
      tick(1);
      total++; if (rif.inp_resn !== 1'b0) $display("FAIL ovr_low[%0d]: inp_resn=%b expected 0", i, rif.inp_resn); else passed++;
    end
    tick(1);
    total++; if (rif.inp_resn !== 1'b1) $display("FAIL ovr_release: inp_resn=%b expected 1", rif.inp_resn); else passed++;
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_valid_press;
    test_soft;
    test_simultaneous;
    test_saturation;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks done", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
